bit_packer: RTL
===============

Name: bit_packer

Overview:
- Upstream stage of the bit-extraction FIFO path.
- Packs variable-length codes (0..15 bits, MSB-first) into 32-bit words for the word FIFO that feeds the bit unpacker.
- Drives that FIFO's push/data pair and honours its full flag.
- Supports an explicit flush that emits a zero-padded final partial word together with its valid-bit count.

Parameters:
OUTWIDTH, 32, packed output word width
INWIDTH, 15, maximum code width per push
INLENWIDTH, 4, width of lenin
OUTLENWIDTH, 6, width of lenout (must hold OUTWIDTH)

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-low reset
pushin  input  1  code valid; accepted only when ready=1
datain  input  INWIDTH  code value, right-justified; bits above lenin ignored
lenin  input  INLENWIDTH  code length 0..15
flushin  input  1  flush request; accepted only when ready=1
fullin  input  1  downstream FIFO full; blocks emission
ready  output  1  combinational; pushin/flushin accepted this cycle
pushout  output  1  registered one-cycle word strobe
dataout  output  OUTWIDTH  registered packed word, first bit in MSB
lenout  output  OUTLENWIDTH  registered valid-bit count of dataout (32, or 1..31 on flush)

Behaviour:
- Reset (reset=0 at posedge): acc=0, count=0, state=RUN, pushout=0, dataout=0, lenout=0. Reset has priority over all activity; any accumulated bits are discarded.
- Accumulator: acc is OUTWIDTH+INWIDTH = 47 bits, left-justified; count ranges 0..46.
- Append on accepted push: the lenin LSBs of datain are placed immediately below the existing count bits. Bits beyond lenin are masked to 0. lenin=0 is accepted as a no-op.
- Emit condition, evaluated at posedge on the registered count: count>=32 and fullin=0.
  - pushout<=1, dataout<=acc[46:15], lenout<=32.
  - acc shifts left by 32; count decreases by 32.
  - An append in the same cycle lands after the shift, so net count = count-32+lenin.
- Otherwise pushout<=0; dataout and lenout hold their values.
- ready:
  - state=RUN and (count<32 or fullin=0). This guarantees count never exceeds 46 and allows full throughput of one code per cycle.
  - ready=0 in state FLUSH.
- Latency: the push that brings count to >=32 is accepted at edge N. pushout is high in the cycle following edge N+1, provided fullin=0 at edge N+1.
- FSM:
  - RUN: on accepted flushin, go to FLUSH. A pushin accepted in the same cycle is appended first.
  - FLUSH: emit full words while count>=32, gated by fullin.
    - count in 1..31 and fullin=0: pushout<=1, dataout=acc top 32 bits with the low bits already 0, lenout<=count; then count<=0, acc<=0, go to RUN.
    - count=0: go to RUN with no pushout.
- Pushes or flushes asserted while ready=0 are ignored (protocol violation; the source must hold them).
- fullin asserted while pushout is high does not retract that push. The downstream FIFO sampled fullin=0 at that edge.

Decomposition:
- Shared package: OUTWIDTH, INWIDTH, INLENWIDTH, OUTLENWIDTH, the FSM state encoding (RUN=0, FLUSH=1), and the localparam ACCWIDTH=OUTWIDTH+INWIDTH.
- One natural sub-module: bit_packer_align, a combinational barrel shifter that masks datain to lenin bits and positions it at offset count within ACCWIDTH. The FSM, counters and output registers stay in the top module.

Test Plan:
- Reset check: hold reset=0 for 2 cycles with random pushin → pushout=0, dataout=0, lenout=0, ready=1. Then flush → no pushout.
- Word fill: 8 consecutive pushes of datain=0xF, lenin=4, fullin=0 → exactly one pushout, dataout=0xFFFFFFFF, lenout=32. Then flush → no further pushout.
- Straddle plus flush: 3 pushes of 0x7FFF, lenin=15 → pushout with dataout=0xFFFFFFFF, lenout=32. Then flushin → pushout with dataout=0xFFF80000, lenout=13; ready returns to 1.
- Bit order and masking: push datain=0x7FFD, lenin=3 (only 101 used), then push 0x0 with lenin=0, then flush → dataout=0xA0000000, lenout=3.
- Backpressure:
  - Hold fullin=1; push 3×15 bits → no pushout; ready drops to 0 once count=45.
  - Release fullin → pushout with 0xFFFFFFFF, ready=1 that cycle.
  - A 15-bit push in the same cycle is accepted, giving count=28.
- Reset mid-operation: push 20 bits, assert reset for one cycle, then flush → no pushout; a following 8×4-bit 0xA sequence yields dataout=0xAAAAAAAA.

Source files
------------

// File: rtl/bit_packer_pkg.sv
// Shared widths and FSM encoding for the bit packer path.
package bit_packer_pkg;

   localparam int OUTWIDTH    = 32;
   localparam int INWIDTH     = 15;
   localparam int INLENWIDTH  = 4;
   localparam int OUTLENWIDTH = 6;
   localparam int ACCWIDTH    = OUTWIDTH + INWIDTH;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/bit_packer_align.sv
// Masks a code to its length and places it MSB-first at bit offset 'offset'
// of the left-justified accumulator.
module bit_packer_align
   import bit_packer_pkg::*;
(
   input  logic [INWIDTH-1:0]     datain,
   input  logic [INLENWIDTH-1:0]  lenin,
   input  logic [OUTLENWIDTH-1:0] offset,
   output logic [ACCWIDTH-1:0]    aligned
);

   localparam logic [INWIDTH-1:0] ONES = '1;

   logic [INWIDTH-1:0]     masked;
   logic [OUTLENWIDTH-1:0] shamt;

   // offset+lenin never exceeds ACCWIDTH-1 while ready gates pushes
   always_comb begin
      masked  = datain & ~(ONES << lenin);
      shamt   = OUTLENWIDTH'(ACCWIDTH) - offset - OUTLENWIDTH'(lenin);
      aligned = {{(ACCWIDTH-INWIDTH){1'b0}}, masked} << shamt;
   end

endmodule

// File: rtl/bit_packer.sv
// Packs 0..15-bit MSB-first codes into 32-bit words for the word FIFO,
// with an explicit flush emitting a zero-padded partial word.
module bit_packer
   import bit_packer_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   pushin,
   input  logic [INWIDTH-1:0]     datain,
   input  logic [INLENWIDTH-1:0]  lenin,
   input  logic                   flushin,
   input  logic                   fullin,
   output logic                   ready,
   output logic                   pushout,
   output logic [OUTWIDTH-1:0]    dataout,
   output logic [OUTLENWIDTH-1:0] lenout
);

   localparam logic [OUTLENWIDTH-1:0] WORDBITS = OUTLENWIDTH'(OUTWIDTH);

   state_t                 state, state_n;
   logic [ACCWIDTH-1:0]    acc, acc_n, base_acc, aligned;
   logic [OUTLENWIDTH-1:0] count, count_n, base_count;
   logic                   emit_full, pushout_n;
   logic [OUTWIDTH-1:0]    dataout_n;
   logic [OUTLENWIDTH-1:0] lenout_n;

   bit_packer_align u_align (
      .datain  (datain),
      .lenin   (lenin),
      .offset  (base_count),
      .aligned (aligned)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= RUN;
         acc     <= '0;
         count   <= '0;
         pushout <= 1'b0;
         dataout <= '0;
         lenout  <= '0;
      end else begin
         state   <= state_n;
         acc     <= acc_n;
         count   <= count_n;
         pushout <= pushout_n;
         dataout <= dataout_n;
         lenout  <= lenout_n;
      end
   end

   // Full-word emission shifts first; a same-cycle append lands after it
   always_comb begin
      ready      = (state == RUN) && ((count < WORDBITS) || !fullin);
      emit_full  = (count >= WORDBITS) && !fullin;
      base_acc   = emit_full ? (acc << OUTWIDTH) : acc;
      base_count = emit_full ? (count - WORDBITS) : count;

      state_n   = state;
      acc_n     = base_acc;
      count_n   = base_count;
      pushout_n = emit_full;
      dataout_n = emit_full ? acc[ACCWIDTH-1 -: OUTWIDTH] : dataout;
      lenout_n  = emit_full ? WORDBITS : lenout;

      case (state)
         RUN: begin
            if (pushin && ready) begin
               acc_n   = base_acc | aligned;
               count_n = base_count + OUTLENWIDTH'(lenin);
            end
            if (flushin && ready)
               state_n = FLUSH;
         end
         FLUSH: begin
            if (count == '0) begin
               state_n = RUN;
            end else if ((count < WORDBITS) && !fullin) begin
               pushout_n = 1'b1;
               dataout_n = acc[ACCWIDTH-1 -: OUTWIDTH];
               lenout_n  = count;
               acc_n     = '0;
               count_n   = '0;
               state_n   = RUN;
            end
         end
         default: state_n = RUN;
      endcase
   end

endmodule
